pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the multicycle/pipelined CPU. It is the generalised successor of the fixed-field IF/ID and ID/EX latches.
- Carries one datapath bundle (DATA_W bits) and one control bundle (CTRL_W bits) plus a valid bit between adjacent stages.
- Supports three distinct per-cycle actions: hold (stall), bubble insertion (flush), and normal load.
- Adds saturating stall/flush event counters for hazard-unit debug.
- Instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with different widths.

Parameters:
- DATA_W, 128, width of the datapath bundle (PC, instr, operands, imm concatenated by the instantiating stage).
- CTRL_W, 16, width of the control bundle (regw, memw, memr, aluctrl, ...); any nonzero bit counts as architectural side effect.
- CLEAR_DATA, 0, 1 = data_q is zeroed on flush/reset; 0 = data_q keeps its value on flush (power saving, data is don't-care when invalid).
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream stage holds a real instruction.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- stall  in  1  hold current contents this cycle.
- flush  in  1  replace contents with a bubble this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered datapath bundle.
- out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0.
- stall_cnt  out  CNT_W  number of cycles with the hold action applied.
- flush_cnt  out  CNT_W  number of cycles with the flush action applied.

Behaviour:
- Priority per rising edge: rst > flush > stall > load.
- rst=1:
  - out_valid=0, out_ctrl=0, out_data=0 regardless of CLEAR_DATA.
  - stall_cnt=0, flush_cnt=0.
  - Reset asserted mid-stall or mid-flush overrides both in the same cycle.
- flush=1 (rst=0), independent of stall:
  - out_valid<=0, out_ctrl<=0.
  - out_data<=0 if CLEAR_DATA=1, else unchanged.
  - flush_cnt increments (saturating). stall_cnt is unchanged even if stall=1.
- stall=1, flush=0:
  - All of out_valid, out_data and out_ctrl hold their previous values.
  - stall_cnt increments (saturating).
  - A held valid instruction must not be lost. Stall is a hold, not a zero; this fixes the older latch behaviour.
- Load (stall=0, flush=0):
  - out_valid<=in_valid, out_data<=in_data.
  - out_ctrl<=in_valid ? in_ctrl : 0. Control is gated by valid, so an invalid input never carries side effects.
- Latency: exactly one cycle from input to output on load. No combinational path from any input to any output.
- Invariant checked every cycle: out_valid==0 implies out_ctrl==0.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes both counters. This takes priority over an increment in the same cycle. Stage registers are unaffected.
- No asynchronous sensitivity anywhere. flush is sampled only at clk edges (the older latch's level-sensitive flush is forbidden).
- Widths are fixed by parameters. The instantiating stage packs and unpacks bundles; no truncation happens inside this block.

Decomposition:
- Shared package cpu_pipe_pkg:
  - Default widths.
  - Bundle field offsets for each stage boundary (ID/EX: PC[127:96], instr[95:64], rd1/rd2, imm32 placement).
  - CTRL bit positions (REGW, MEMW, MEMR, MEM2R, REGDST, ALUSRC, PCWR, PCSRC[1:0], ALUCTRL[4:0]).
- One sub-module, sat_counter (CNT_W; inputs clr, inc; output count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: hold rst=1 with in_valid=1, in_ctrl=16'hFFFF -> next edge out_valid=0, out_ctrl=0, out_data=0, both counters 0.
- Load: in_valid=1, in_data=128'h0040_0010_..., in_ctrl=16'h00A5 -> one edge later outputs equal the inputs. Then in_valid=0, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0.
- Stall: load in_ctrl=16'h0011, then stall=1 for 3 cycles while inputs change -> outputs constant at 16'h0011 and valid=1, stall_cnt=3; release -> new input appears after 1 edge.
- Flush vs stall: stall=1 and flush=1 on the same edge -> out_valid=0, out_ctrl=0, flush_cnt=1, stall_cnt unchanged. out_data=0 with CLEAR_DATA=1, unchanged with CLEAR_DATA=0.
- Saturation: CNT_W=4, stall held for 20 cycles -> stall_cnt stops at 15. Assert cnt_clr with stall=1 on the same edge -> stall_cnt=0.
- Reset mid-operation: stall=1 with valid data held, rst pulsed for one cycle -> all outputs and counters cleared. Next load behaves normally.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: default widths,
// bundle field placement and control-bit positions.
package cpu_pipe_pkg;

    // Default bundle and counter widths.
    localparam int DEF_DATA_W = 128;
    localparam int DEF_CTRL_W = 16;
    localparam int DEF_CNT_W  = 16;

    // ID/EX datapath bundle placement (msb/lsb of each field).
    localparam int IDEX_PC_MSB    = 127;
    localparam int IDEX_PC_LSB    = 96;
    localparam int IDEX_INSTR_MSB = 95;
    localparam int IDEX_INSTR_LSB = 64;
    localparam int IDEX_RD1_MSB   = 63;
    localparam int IDEX_RD1_LSB   = 48;
    localparam int IDEX_RD2_MSB   = 47;
    localparam int IDEX_RD2_LSB   = 32;
    localparam int IDEX_IMM_MSB   = 31;
    localparam int IDEX_IMM_LSB   = 0;

    // Control bundle bit positions.
    localparam int CTRL_REGW       = 0;
    localparam int CTRL_MEMW       = 1;
    localparam int CTRL_MEMR       = 2;
    localparam int CTRL_MEM2R      = 3;
    localparam int CTRL_REGDST     = 4;
    localparam int CTRL_ALUSRC     = 5;
    localparam int CTRL_PCWR       = 6;
    localparam int CTRL_PCSRC_LSB  = 7;
    localparam int CTRL_PCSRC_MSB  = 8;
    localparam int CTRL_ALUCTL_LSB = 9;
    localparam int CTRL_ALUCTL_MSB = 13;

    // Per-cycle action applied to a stage register (reset is handled apart).
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } stage_act_e;

    // Flush beats stall; stall beats a normal load.
    function automatic stage_act_e decode_act(input logic stall, input logic flush);
        if (flush)      return ACT_BUBBLE;
        else if (stall) return ACT_HOLD;
        else            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/bundle interface between two adjacent pipeline stages.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    // Upstream/driving side.
    modport master (
        output in_valid, in_data, in_ctrl,
        input  out_valid, out_data, out_ctrl
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_data, in_ctrl,
        output out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear, else step unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: load / hold (stall) / bubble (flush),
// with control gated by valid and saturating stall/flush debug counters.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    stage_act_e        act;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    assign act = decode_act(stall, flush);

    // Next-state for the stage contents; control never survives without valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        case (act)
            ACT_LOAD: begin
                valid_d = bus.in_valid;
                data_d  = bus.in_data;
                ctrl_d  = bus.in_valid ? bus.in_ctrl : '0;
            end
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                // Data is don't-care once invalid; only clear it when asked to.
                if (CLEAR_DATA) data_d = '0;
            end
            default: ;  // ACT_HOLD keeps everything, including a valid instruction
        endcase
    end

    // Stage registers; reset clears data too, whatever CLEAR_DATA says.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ctrl  = ctrl_q;

    // A stall masked by a flush is not a hold, so it is not counted.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (act == ACT_HOLD),
        .count_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (act == ACT_BUBBLE),
        .count_o (flush_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (CLEAR_DATA=0 and 1, CNT_W=4) share
// the same directed stimulus; expected results go through a scoreboard queue.
module tb_pipe_stage_reg;
    localparam int DW = 128;
    localparam int CW = 16;
    localparam int NW = 4;

    localparam logic [DW-1:0] D1 = 128'h0040_0010_1234_5678_0000_0001_0000_00A5;
    localparam logic [DW-1:0] D2 = 128'h0040_0014_DEAD_BEEF_0000_0002_FFFF_FFFC;
    localparam logic [DW-1:0] D3 = 128'h0040_0018_0000_0011_0000_0003_0000_0011;
    localparam logic [DW-1:0] D4 = 128'h0040_001C_CAFE_F00D_0000_0004_0000_0022;
    localparam logic [DW-1:0] D5 = 128'h0040_0020_5555_AAAA_0000_0005_0000_0033;
    localparam logic [DW-1:0] Z  = '0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [CW-1:0] c;
        int            s;
        int            f;
    } exp_t;

    logic clk = 1'b0;
    logic rst, stall, flush, cnt_clr;
    logic [NW-1:0] scnt0, fcnt0, scnt1, fcnt1;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0), .CNT_W(NW)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .stall(stall), .flush(flush),
        .cnt_clr(cnt_clr), .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1), .CNT_W(NW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .stall(stall), .flush(flush),
        .cnt_clr(cnt_clr), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Drive one cycle of inputs and queue what should appear after the next edge.
    task automatic step(input logic r, input logic iv, input logic [DW-1:0] id,
                        input logic [CW-1:0] ic, input logic st, input logic fl,
                        input logic cc, input logic ev, input logic [DW-1:0] ed0,
                        input logic [DW-1:0] ed1, input logic [CW-1:0] ec,
                        input int es, input int ef);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; flush = fl; cnt_clr = cc;
        bus0.in_valid = iv; bus0.in_data = id; bus0.in_ctrl = ic;
        bus1.in_valid = iv; bus1.in_data = id; bus1.in_ctrl = ic;
        e.v = ev; e.d0 = ed0; e.d1 = ed1; e.c = ec; e.s = es; e.f = ef;
        q.push_back(e);
    endtask

    // Monitor: each queued entry corresponds to exactly one capturing edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                bit   bad;
                e   = q.pop_front();
                bad = 0;
                n_vec++;
                if (bus0.out_valid !== e.v || bus1.out_valid !== e.v) begin
                    $display("FAIL vec%0d valid: got %b/%b want %b", n_vec, bus0.out_valid, bus1.out_valid, e.v);
                    bad = 1;
                end
                if (bus0.out_ctrl !== e.c || bus1.out_ctrl !== e.c) begin
                    $display("FAIL vec%0d ctrl: got %h/%h want %h", n_vec, bus0.out_ctrl, bus1.out_ctrl, e.c);
                    bad = 1;
                end
                if (bus0.out_data !== e.d0) begin
                    $display("FAIL vec%0d data(keep): got %h want %h", n_vec, bus0.out_data, e.d0);
                    bad = 1;
                end
                if (bus1.out_data !== e.d1) begin
                    $display("FAIL vec%0d data(clear): got %h want %h", n_vec, bus1.out_data, e.d1);
                    bad = 1;
                end
                if (scnt0 !== NW'(e.s) || scnt1 !== NW'(e.s)) begin
                    $display("FAIL vec%0d stall_cnt: got %0d/%0d want %0d", n_vec, scnt0, scnt1, e.s);
                    bad = 1;
                end
                if (fcnt0 !== NW'(e.f) || fcnt1 !== NW'(e.f)) begin
                    $display("FAIL vec%0d flush_cnt: got %0d/%0d want %0d", n_vec, fcnt0, fcnt1, e.f);
                    bad = 1;
                end
                if ((bus0.out_valid === 1'b0 && bus0.out_ctrl !== '0) ||
                    (bus1.out_valid === 1'b0 && bus1.out_ctrl !== '0)) begin
                    $display("FAIL vec%0d invalid-carries-ctrl: got %h/%h want 0", n_vec, bus0.out_ctrl, bus1.out_ctrl);
                    bad = 1;
                end
                if (bad) n_bad++;
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_ctrl = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_ctrl = '0;

        //   rst iv id  ic        st fl cc   ev d0  d1  c         s  f
        // reset with a live, fully-asserted input
        step(1, 1, D1, 16'hFFFF, 0, 0, 0,   0, Z,  Z,  16'h0000, 0, 0);
        // plain load, then invalid input: data follows, ctrl gated off
        step(0, 1, D1, 16'h00A5, 0, 0, 0,   1, D1, D1, 16'h00A5, 0, 0);
        step(0, 0, D2, 16'hFFFF, 0, 0, 0,   0, D2, D2, 16'h0000, 0, 0);
        // load then stall 3 cycles while inputs change
        step(0, 1, D3, 16'h0011, 0, 0, 0,   1, D3, D3, 16'h0011, 0, 0);
        step(0, 1, D4, 16'h0022, 1, 0, 0,   1, D3, D3, 16'h0011, 1, 0);
        step(0, 1, D4, 16'h0022, 1, 0, 0,   1, D3, D3, 16'h0011, 2, 0);
        step(0, 1, D4, 16'h0022, 1, 0, 0,   1, D3, D3, 16'h0011, 3, 0);
        // release: new input appears after one edge
        step(0, 1, D4, 16'h0022, 0, 0, 0,   1, D4, D4, 16'h0022, 3, 0);
        // stall and flush together: flush wins, stall not counted
        step(0, 1, D5, 16'h0033, 1, 1, 0,   0, D4, Z,  16'h0000, 3, 1);
        step(0, 1, D5, 16'h0033, 0, 0, 0,   1, D5, D5, 16'h0033, 3, 1);
        // flush alone
        step(0, 0, D2, 16'h0000, 0, 1, 0,   0, D5, Z,  16'h0000, 3, 2);
        step(0, 1, D1, 16'h00A5, 0, 0, 0,   1, D1, D1, 16'h00A5, 3, 2);
        // long stall: 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++)
            step(0, 0, D2, 16'hFFFF, 1, 0, 0, 1, D1, D1, 16'h00A5, (3 + k > 15) ? 15 : 3 + k, 2);
        // clear beats increment on the same edge; stage untouched
        step(0, 0, D2, 16'hFFFF, 1, 0, 1,   1, D1, D1, 16'h00A5, 0, 0);
        step(0, 0, D2, 16'hFFFF, 1, 0, 0,   1, D1, D1, 16'h00A5, 1, 0);
        step(0, 0, D2, 16'hFFFF, 0, 1, 1,   0, D1, Z,  16'h0000, 0, 0);
        step(0, 1, D2, 16'h0101, 0, 1, 0,   0, D1, Z,  16'h0000, 0, 1);
        step(0, 1, D2, 16'h0101, 0, 0, 0,   1, D2, D2, 16'h0101, 0, 1);
        step(0, 1, D3, 16'h0011, 1, 0, 0,   1, D2, D2, 16'h0101, 1, 1);
        // reset in the middle of a stall clears everything
        step(1, 1, D3, 16'h0011, 1, 1, 0,   0, Z,  Z,  16'h0000, 0, 0);
        // normal load afterwards
        step(0, 1, D3, 16'h0011, 0, 0, 0,   1, D3, D3, 16'h0011, 0, 0);

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
